// File: rtl/sram_rd_streamer.sv
// Streams N consecutive 64-bit words out of a single-port SRAM into a ready/valid
// beat stream, with a small credit-limited FIFO absorbing downstream back-pressure.
module sram_rd_streamer #(
    parameter int MAX_ADDR_WIDTH = 32,
    parameter int SRAM_WIDTH_O   = 64,
    parameter int LEN_WIDTH      = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic [MAX_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]      num_beats_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      sram_en_o,
    output logic                      sram_we_o,
    output logic [MAX_ADDR_WIDTH-1:0] sram_addr_o,
    output logic [SRAM_WIDTH_O-1:0]   sram_wdata_o,
    input  logic [SRAM_WIDTH_O-1:0]   sram_rdata_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [SRAM_WIDTH_O-1:0]   m_data_o,
    output logic                      m_last_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                    state_q, state_d;
    logic [MAX_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      total_q, total_d;
    logic [LEN_WIDTH-1:0]      issuedCnt_q, issuedCnt_d;
    logic [LEN_WIDTH-1:0]      beatCnt_q, beatCnt_d;
    logic                      done_q, done_d;
    logic                      inflight_q;
    logic [CNT_W-1:0]          fifoCount_q;
    logic [PTR_W-1:0]          wrPtr_q, rdPtr_q;
    logic [SRAM_WIDTH_O-1:0]   mem_q [FIFO_DEPTH];

    logic             creditOk;
    logic             issue;
    logic             push;
    logic             pop;
    logic             headIsLast;
    logic [CNT_W-1:0] occupancy;

    // A read is only issued if its data is guaranteed a free slot when it returns,
    // which is what lets the FIFO write be unconditional.
    assign occupancy  = fifoCount_q + CNT_W'(inflight_q);
    assign creditOk   = occupancy < CNT_W'(FIFO_DEPTH);
    assign issue      = (state_q == RUN) && (issuedCnt_q < total_q) && creditOk;
    assign push       = inflight_q;
    assign pop        = m_valid_o && m_ready_i;
    assign headIsLast = (beatCnt_q == total_q - LEN_WIDTH'(1));

    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q || ((state_q == DRAIN) && pop && m_last_o);
    assign sram_en_o    = issue;
    assign sram_we_o    = 1'b0;
    assign sram_addr_o  = issue ? addr_q : '0;
    assign sram_wdata_o = '0;
    assign m_valid_o    = (fifoCount_q != '0);
    assign m_data_o     = m_valid_o ? mem_q[rdPtr_q] : '0;
    assign m_last_o     = m_valid_o && headIsLast;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        total_d     = total_q;
        issuedCnt_d = issuedCnt_q;
        beatCnt_d   = beatCnt_q;
        done_d      = 1'b0;

        if (pop) begin
            beatCnt_d = beatCnt_q + LEN_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (num_beats_i != '0) begin
                        addr_d      = base_addr_i;
                        total_d     = num_beats_i;
                        issuedCnt_d = '0;
                        beatCnt_d   = '0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    issuedCnt_d = issuedCnt_q + LEN_WIDTH'(1);
                    addr_d      = addr_q + MAX_ADDR_WIDTH'(8);
                    if (issuedCnt_q == total_q - LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            total_q     <= '0;
            issuedCnt_q <= '0;
            beatCnt_q   <= '0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            issuedCnt_q <= issuedCnt_d;
            beatCnt_q   <= beatCnt_d;
            done_q      <= done_d;
            inflight_q  <= issue;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fifoCount_q <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                fifoCount_q <= fifoCount_q + CNT_W'(1);
            end else if (!push && pop) begin
                fifoCount_q <= fifoCount_q - CNT_W'(1);
            end
        end
    end

    // Storage is left unreset; the count and pointers alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wrPtr_q] <= sram_rdata_i;
        end
    end

endmodule

// File: doc/sram_rd_streamer.md
SRAM_RD_STREAMER -- requirements
Module: sram_rd_streamer

Interface
REQ-001 Parameter MAX_ADDR_WIDTH, default 32: byte-address width shared with the 64-bit SRAM.
REQ-002 Parameter SRAM_WIDTH_O, default 64: beat width in bits.
REQ-003 Parameter LEN_WIDTH, default 16: beat-count width.
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer entries; power of two, at least 2.
REQ-005 Ports clk_i (input, 1) and rst_n_i (input, 1): one clock; reset is asynchronous and active-low.
REQ-006 start_i (input, 1): request pulse, sampled only in IDLE.
REQ-007 base_addr_i (input, MAX_ADDR_WIDTH): first byte address; may be unaligned.
REQ-008 num_beats_i (input, LEN_WIDTH): number of 64-bit beats to read.
REQ-009 busy_o (output, 1): high while not IDLE.
REQ-010 done_o (output, 1): one-cycle pulse when the request completes.
REQ-011 sram_en_o (output, 1), sram_we_o (output, 1), sram_addr_o (output, MAX_ADDR_WIDTH), sram_wdata_o (output, SRAM_WIDTH_O): SRAM command port.
REQ-012 sram_rdata_i (input, SRAM_WIDTH_O): SRAM read data, valid exactly one cycle after a read command.
REQ-013 m_valid_o (output, 1), m_ready_i (input, 1), m_data_o (output, SRAM_WIDTH_O), m_last_o (output, 1): output beat stream.

Function
REQ-014 The state machine SHALL have three states: IDLE, RUN, and DRAIN.
REQ-015 IDLE with start_i=1 and num_beats_i>0: latch base_addr_i and num_beats_i, then go to RUN.
REQ-016 IDLE with start_i=1 and num_beats_i=0: stay in IDLE, issue no reads, and pulse done_o on the next cycle.
REQ-017 start_i outside IDLE SHALL be ignored.
REQ-018 Read k (k = 0..N-1) SHALL use sram_addr_o = base + 8*k, modulo 2^MAX_ADDR_WIDTH.
REQ-019 sram_we_o SHALL be held at 0 and sram_wdata_o at 0.
REQ-020 A read SHALL be issued (sram_en_o=1) in RUN only when issued < N and fifo_count + inflight < FIFO_DEPTH.
  - inflight is 1 if a read was issued in the previous cycle, else 0.
REQ-021 With m_ready_i held at 1, reads SHALL issue back-to-back, one per cycle.
REQ-022 sram_rdata_i SHALL be written into the FIFO in the cycle after the corresponding sram_en_o, unconditionally.
  - The credit rule of REQ-020 guarantees this write never overflows the FIFO.
REQ-023 m_valid_o SHALL equal (fifo_count != 0), and m_data_o SHALL be the FIFO head.
REQ-024 A beat is consumed when m_valid_o and m_ready_i are both 1.
  - m_data_o SHALL be held stable while m_valid_o=1 and m_ready_i=0.
REQ-025 Simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
  - FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 m_last_o SHALL be 1 only when the head beat is beat N-1.
REQ-027 RUN SHALL go to DRAIN in the cycle after the last read is issued.
REQ-028 DRAIN SHALL go to IDLE on the handshake of the beat with m_last_o=1.
  - done_o SHALL pulse in that same cycle.
REQ-029 Minimum latency from start_i to the first m_valid_o SHALL be 3 cycles: latch, issue, capture.
REQ-030 A request with N=1 SHALL behave as a single beat with m_last_o=1.
REQ-031 A request with N=2^LEN_WIDTH-1 SHALL complete without counter overflow.

Reset
REQ-032 When rst_n_i=0, the block SHALL immediately go to IDLE and clear all of the following:
  - FIFO count and pointers, issue and beat counters, inflight.
  - busy_o, done_o, sram_en_o, sram_we_o, m_valid_o, m_last_o all driven to 0.
  - sram_addr_o, sram_wdata_o, m_data_o all driven to 0.
REQ-033 Reset asserted mid-request SHALL discard all buffered and in-flight data; no done_o SHALL follow.
REQ-034 After reset deasserts, the first start_i SHALL be accepted normally.

Verification
REQ-035 Base 0x100, N=4, m_ready_i=1:
  - sram_addr_o = 0x100, 0x108, 0x110, 0x118 on consecutive cycles.
  - 4 beats out, m_last_o on beat 3.
  - done_o pulses once; busy_o then falls.
REQ-036 Base 0x103 (unaligned), N=2:
  - sram_addr_o = 0x103, 0x10B.
  - m_data_o equals SRAM model output for those addresses, in order.
REQ-037 N=8, m_ready_i=0 for 20 cycles, then 1:
  - Exactly FIFO_DEPTH=4 reads issued, then sram_en_o=0 until drain starts.
  - No data lost or duplicated; 8 beats delivered in order.
REQ-038 Random m_ready_i (50%), N=100, base 0xFFFFFFF8:
  - Addresses wrap to 0x0 after the first beat.
  - Scoreboard matches all 100 beats; exactly one done_o.
REQ-039 Edge requests:
  - N=0: done_o pulses next cycle, sram_en_o never asserts.
  - start_i while busy: ignored, sram_addr_o sequence unchanged.
REQ-040 rst_n_i pulled low after beat 2 of N=10:
  - All outputs 0 immediately; no done_o.
  - A new request (base 0x40, N=1) then yields exactly one beat with m_last_o=1.
